// File: rtl/c2_initiator.sv
// C2 bus initiator: moves one cache line per request as BUS_SIZE-bit beats over the C2 bus.
// Define C2_TIMEOUT_EN to bound the RD_WAIT/WR_WAIT states by TIMEOUT_CYCLES and flag resp_err.
module c2_initiator #(
    parameter int MEM_ADDR_SIZE     = 19,
    parameter int CACHE_OFFSET_SIZE = 4,
    parameter int BUS_SIZE          = 16,
    parameter int CACHE_LINE_SIZE   = 16,
    parameter int TIMEOUT_CYCLES    = 100
) (
    input  logic                                     clk,
    input  logic                                     reset,
    input  logic                                     req_valid,
    output logic                                     req_ready,
    input  logic                                     req_write,
    input  logic [MEM_ADDR_SIZE-CACHE_OFFSET_SIZE-1:0] req_addr,
    input  logic [CACHE_LINE_SIZE*8-1:0]             req_wdata,
    output logic                                     resp_valid,
    output logic                                     resp_err,
    output logic [CACHE_LINE_SIZE*8-1:0]             resp_rdata,
    output logic [MEM_ADDR_SIZE-CACHE_OFFSET_SIZE-1:0] c2_addr,
    output logic [1:0]                               c2_cmd_out,
    input  logic [1:0]                               c2_cmd_in,
    output logic [BUS_SIZE-1:0]                      c2_data_out,
    output logic                                     c2_data_oe,
    input  logic [BUS_SIZE-1:0]                      c2_data_in
);
    localparam int LA     = MEM_ADDR_SIZE - CACHE_OFFSET_SIZE;
    localparam int LW     = CACHE_LINE_SIZE * 8;
    localparam int NBEATS = LW / BUS_SIZE;
    localparam int BW     = (NBEATS > 1) ? $clog2(NBEATS) : 1;

    localparam logic [1:0]    CMD_NOP      = 2'd0;
    localparam logic [1:0]    CMD_RESPONSE = 2'd1;
    localparam logic [1:0]    CMD_READ     = 2'd2;
    localparam logic [1:0]    CMD_WRITE    = 2'd3;
    localparam logic [BW-1:0] LAST_BEAT    = BW'(NBEATS - 1);

    typedef enum logic [2:0] {
        S_IDLE, S_RD_CMD, S_RD_WAIT, S_RD_DATA, S_WR_DATA, S_WR_WAIT, S_DONE
    } state_e;

    state_e          state_q, state_d;
    logic [BW-1:0]   beat_q, beat_d;
    logic [LA-1:0]   addr_q, addr_d;
    logic [LW-1:0]   wdata_q, wdata_d;
    logic [LW-1:0]   rbuf_q, rbuf_d;
    logic [LW-1:0]   rdata_q, rdata_d;
    logic [1:0]      cmd_q, cmd_d;
    logic [BUS_SIZE-1:0] dout_q, dout_d;
    logic            oe_q, oe_d;
    logic            rvalid_q, rvalid_d;
    logic            rerr_q, rerr_d;
    logic            resp_seen;
    logic            tmo_hit;
    logic            tmo_fire;

    assign resp_seen = (c2_cmd_in == CMD_RESPONSE);

`ifdef C2_TIMEOUT_EN
    localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
    logic [TW-1:0] tmo_q, tmo_d;

    assign tmo_hit = ((state_q == S_RD_WAIT) || (state_q == S_WR_WAIT)) &&
                     (tmo_q == TW'(TIMEOUT_CYCLES - 1));

    // Counts only while staying in a wait state, so each entry starts from zero.
    always_comb begin
        tmo_d = '0;
        if (((state_q == S_RD_WAIT) || (state_q == S_WR_WAIT)) && (state_d == state_q))
            tmo_d = tmo_q + 1'b1;
    end

    always_ff @(posedge clk) begin
        if (reset) tmo_q <= '0;
        else       tmo_q <= tmo_d;
    end
`else
    // Timeout disabled: the wait states never expire.
    assign tmo_hit = (TIMEOUT_CYCLES < 0);
`endif

    // State register
    always_ff @(posedge clk) begin
        // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
        if (reset) begin
            state_q <= S_IDLE;
            beat_q  <= '0;
        end else begin
            state_q <= state_d;
            beat_q  <= beat_d;
        end
    end

    // Next-state logic
    always_comb begin
        // NOTE: defaults first so no path through the case leaves a variable unassigned (no latches).
        state_d  = state_q;
        beat_d   = beat_q;
        tmo_fire = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (req_valid) begin
                    state_d = req_write ? S_WR_DATA : S_RD_CMD;
                    beat_d  = '0;
                end
            end
            S_RD_CMD: state_d = S_RD_WAIT;
            S_RD_WAIT: begin
                if (resp_seen) begin
                    state_d = S_RD_DATA;
                    beat_d  = BW'(1);
                end else if (tmo_hit) begin
                    state_d  = S_DONE;
                    tmo_fire = 1'b1;
                end
            end
            S_RD_DATA: begin
                beat_d = beat_q + 1'b1;
                if (beat_q == LAST_BEAT) state_d = S_DONE;
            end
            S_WR_DATA: begin
                beat_d = beat_q + 1'b1;
                if (beat_q == LAST_BEAT) state_d = S_WR_WAIT;
            end
            S_WR_WAIT: begin
                if (resp_seen) begin
                    state_d = S_DONE;
                end else if (tmo_hit) begin
                    state_d  = S_DONE;
                    tmo_fire = 1'b1;
                end
            end
            S_DONE:  state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    // Output logic: bus outputs are computed from the next state so they appear registered.
    always_comb begin
        cmd_d    = CMD_NOP;
        oe_d     = 1'b0;
        dout_d   = '0;
        addr_d   = addr_q;
        wdata_d  = wdata_q;
        rbuf_d   = rbuf_q;
        rdata_d  = rdata_q;
        rvalid_d = (state_d == S_DONE);
        rerr_d   = tmo_fire;

        if ((state_q == S_IDLE) && req_valid) begin
            addr_d  = req_addr;
            wdata_d = req_wdata;
        end

        if (((state_q == S_RD_WAIT) && resp_seen) || (state_q == S_RD_DATA))
            rbuf_d[beat_q*BUS_SIZE +: BUS_SIZE] = c2_data_in;

        if ((state_q == S_RD_DATA) && (state_d == S_DONE))
            rdata_d = rbuf_d;

        case (state_d)
            S_RD_CMD: cmd_d = CMD_READ;
            S_WR_DATA: begin
                cmd_d  = CMD_WRITE;
                oe_d   = 1'b1;
                dout_d = wdata_d[beat_d*BUS_SIZE +: BUS_SIZE];
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            addr_q   <= '0;
            wdata_q  <= '0;
            rbuf_q   <= '0;
            rdata_q  <= '0;
            cmd_q    <= CMD_NOP;
            dout_q   <= '0;
            oe_q     <= 1'b0;
            rvalid_q <= 1'b0;
            rerr_q   <= 1'b0;
        end else begin
            addr_q   <= addr_d;
            wdata_q  <= wdata_d;
            rbuf_q   <= rbuf_d;
            rdata_q  <= rdata_d;
            cmd_q    <= cmd_d;
            dout_q   <= dout_d;
            oe_q     <= oe_d;
            rvalid_q <= rvalid_d;
            rerr_q   <= rerr_d;
        end
    end

    assign req_ready   = (state_q == S_IDLE);
    assign resp_valid  = rvalid_q;
    assign resp_err    = rerr_q;
    assign resp_rdata  = rdata_q;
    assign c2_addr     = addr_q;
    assign c2_cmd_out  = cmd_q;
    assign c2_data_out = dout_q;
    assign c2_data_oe  = oe_q;

endmodule

// File: tb/tb_c2_initiator.sv
// Self-checking bench for c2_initiator: per-cycle expectations derived from transaction timing rules.
// Define C2_TIMEOUT_EN for both bench and RTL to also exercise the wait-state timeout.
module tb_c2_initiator;
    localparam int LA   = 15;
    localparam int LW   = 128;
    localparam int BUS  = 16;
    localparam int NB   = 8;
    localparam int TMO  = 100;
    localparam int MAXC = 8000;

    localparam logic [1:0] NOP  = 2'd0;
    localparam logic [1:0] RESP = 2'd1;
    localparam logic [1:0] RD   = 2'd2;
    localparam logic [1:0] WR   = 2'd3;

    logic           clk = 1'b0;
    logic           reset = 1'b1;
    logic           req_valid = 1'b0;
    logic           req_ready;
    logic           req_write = 1'b0;
    logic [LA-1:0]  req_addr = '0;
    logic [LW-1:0]  req_wdata = '0;
    logic           resp_valid;
    logic           resp_err;
    logic [LW-1:0]  resp_rdata;
    logic [LA-1:0]  c2_addr;
    logic [1:0]     c2_cmd_out;
    logic [1:0]     c2_cmd_in = 2'd0;
    logic [BUS-1:0] c2_data_out;
    logic           c2_data_oe;
    logic [BUS-1:0] c2_data_in = '0;

    c2_initiator #(.TIMEOUT_CYCLES(TMO)) dut (
        .clk(clk), .reset(reset),
        .req_valid(req_valid), .req_ready(req_ready), .req_write(req_write),
        .req_addr(req_addr), .req_wdata(req_wdata),
        .resp_valid(resp_valid), .resp_err(resp_err), .resp_rdata(resp_rdata),
        .c2_addr(c2_addr), .c2_cmd_out(c2_cmd_out), .c2_cmd_in(c2_cmd_in),
        .c2_data_out(c2_data_out), .c2_data_oe(c2_data_oe), .c2_data_in(c2_data_in)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // Expected outputs per clock period, filled in by the driver ahead of time.
    logic [1:0]     e_cmd  [MAXC];
    logic [LA-1:0]  e_addr [MAXC];
    logic [BUS-1:0] e_dout [MAXC];
    logic [LW-1:0]  e_line [MAXC];
    bit             e_oe   [MAXC];
    bit             e_rv   [MAXC];
    bit             e_err  [MAXC];
    bit             e_ready[MAXC];
    bit             e_upd  [MAXC];
    bit             e_rst  [MAXC];

    int            n_checks = 0;
    int            n_fail   = 0;
    bit            chk_en   = 1'b0;
    logic [LW-1:0] m_rdata  = '0;

    task automatic check(input string name, input logic [LW-1:0] act, input logic [LW-1:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s @cyc %0d: got %h expected %h", name, cyc, act, exp);
        end
    endtask

    function automatic void clear_exp(input int c);
        e_cmd[c] = NOP;  e_addr[c] = '0; e_dout[c] = '0; e_line[c] = '0;
        e_oe[c] = 1'b0;  e_rv[c] = 1'b0; e_err[c] = 1'b0; e_ready[c] = 1'b1;
        e_upd[c] = 1'b0; e_rst[c] = 1'b0;
    endfunction

    function automatic logic [1:0] rnd_nonresp();
        case ($urandom_range(0, 2))
            0:       return NOP;
            1:       return RD;
            default: return WR;
        endcase
    endfunction

    function automatic logic [1:0] rnd_any();
        return 2'($urandom_range(0, 3));
    endfunction

    always @(negedge clk) begin
        if (chk_en && cyc < MAXC) begin
            if (e_rst[cyc]) m_rdata = '0;
            if (e_upd[cyc]) m_rdata = e_line[cyc];
            check("req_ready", req_ready, e_ready[cyc]);
            check("c2_cmd_out", c2_cmd_out, e_cmd[cyc]);
            if (e_cmd[cyc] != NOP) check("c2_addr", c2_addr, e_addr[cyc]);
            check("c2_data_oe", c2_data_oe, e_oe[cyc]);
            if (e_oe[cyc]) check("c2_data_out", c2_data_out, e_dout[cyc]);
            check("resp_valid", resp_valid, e_rv[cyc]);
            if (e_rv[cyc]) check("resp_err", resp_err, e_err[cyc]);
            check("resp_rdata", resp_rdata, m_rdata);
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic idle(input int n);
        repeat (n) begin
            c2_cmd_in  = rnd_nonresp();
            c2_data_in = BUS'($urandom);
            step();
        end
    endtask

    // Read: RESPONSE d cycles after READ (d<0: never), optional reset during beat abort_beat.
    task automatic do_read(input logic [LA-1:0] addr, input int d, input logic [LW-1:0] line,
                           input int abort_beat, input bit hold);
        int t, r, done;
        t    = cyc;
        r    = t + 1 + d;
        done = (d < 0) ? t + 2 + TMO : r + NB;
        for (int c = t + 1; c <= done; c++) e_ready[c] = 1'b0;
        e_cmd[t+1]  = RD;
        e_addr[t+1] = addr;
        e_rv[done]  = 1'b1;
        e_err[done] = (d < 0);
        if (d >= 0) begin
            e_upd[done]  = 1'b1;
            e_line[done] = line;
        end
        req_valid = 1'b1;
        req_write = 1'b0;
        req_addr  = addr;
        req_wdata = {$urandom, $urandom, $urandom, $urandom};
        for (int p = t; p < done; p++) begin
            if (p > t && !hold) req_valid = 1'b0;
            if (d >= 0 && p >= r && p < r + NB) begin
                c2_cmd_in  = (p == r) ? RESP : rnd_any();
                c2_data_in = line[(p-r)*BUS +: BUS];
            end else begin
                c2_cmd_in  = rnd_nonresp();
                c2_data_in = BUS'($urandom);
            end
            if (abort_beat >= 0 && d >= 0 && p == r + abort_beat) begin
                reset = 1'b1;
                for (int c = p + 1; c <= done; c++) clear_exp(c);
                e_rst[p+1] = 1'b1;
                step();
                reset     = 1'b0;
                req_valid = 1'b0;
                return;
            end
            step();
        end
        if (!hold) req_valid = 1'b0;
        c2_cmd_in  = rnd_nonresp();
        c2_data_in = BUS'($urandom);
        step();
    endtask

    // Write: RESPONSE d cycles after the last WRITE beat.
    task automatic do_write(input logic [LA-1:0] addr, input logic [LW-1:0] line, input int d,
                            input bit hold, input bit pin);
        int t, r, done;
        t    = cyc;
        r    = t + NB + d;
        done = r + 1;
        for (int c = t + 1; c <= done; c++) e_ready[c] = 1'b0;
        for (int i = 0; i < NB; i++) begin
            e_cmd[t+1+i]  = WR;
            e_addr[t+1+i] = addr;
            e_oe[t+1+i]   = 1'b1;
            e_dout[t+1+i] = line[i*BUS +: BUS];
        end
        e_rv[done]  = 1'b1;
        e_err[done] = 1'b0;
        req_valid = 1'b1;
        req_write = 1'b1;
        req_addr  = addr;
        req_wdata = line;
        for (int p = t; p < done; p++) begin
            if (p > t && !hold) req_valid = 1'b0;
            if (p == r)                         c2_cmd_in = RESP;
            else if (p >= t + 1 && p <= t + NB) c2_cmd_in = rnd_any();
            else                                c2_cmd_in = rnd_nonresp();
            c2_data_in = BUS'($urandom);
            step();
            if (pin && cyc == t + 1)  check("pin_wr_first_beat", c2_data_out, 16'h0100);
            if (pin && cyc == t + NB) check("pin_wr_last_beat", c2_data_out, 16'h0F0E);
        end
        if (!hold) req_valid = 1'b0;
        c2_cmd_in  = rnd_nonresp();
        c2_data_in = BUS'($urandom);
        step();
    endtask

    logic [LW-1:0] line;
    logic [LA-1:0] addr;
    int            dly;
    bit            hold;

    initial begin
        for (int c = 0; c < MAXC; c++) clear_exp(c);
        reset = 1'b1;
        repeat (3) step();
        reset  = 1'b0;
        chk_en = 1'b1;
        check("pin_reset_ready", req_ready, 1'b1);
        check("pin_reset_cmd", c2_cmd_out, 2'b00);
        check("pin_reset_oe", c2_data_oe, 1'b0);
        check("pin_reset_rv", resp_valid, 1'b0);
        idle(2);

        // Read of 0x1234, RESPONSE three cycles after READ, beats 1..8
        for (int i = 0; i < NB; i++) line[i*BUS +: BUS] = BUS'(i + 1);
        do_read(15'h1234, 3, line, -1, 1'b0);
        check("pin_read_line", resp_rdata, 128'h0008_0007_0006_0005_0004_0003_0002_0001);
        idle(1);

        // Write of 0x7FFF, beat i = {2i+1, 2i}
        for (int i = 0; i < NB; i++) line[i*BUS +: BUS] = {8'(2*i + 1), 8'(2*i)};
        do_write(15'h7FFF, line, 1, 1'b0, 1'b1);
        idle(2);

        // Back-to-back write then read with req_valid held
        line = {$urandom, $urandom, $urandom, $urandom};
        do_write(LA'($urandom), line, 2, 1'b1, 1'b0);
        line = {$urandom, $urandom, $urandom, $urandom};
        do_read(LA'($urandom), 1, line, -1, 1'b0);
        idle(2);

        // Reset during RD_DATA beat 4, then a fresh read
        line = {$urandom, $urandom, $urandom, $urandom};
        do_read(LA'($urandom), 2, line, 4, 1'b0);
        check("pin_abort_cmd", c2_cmd_out, 2'b00);
        check("pin_abort_rv", resp_valid, 1'b0);
        check("pin_abort_rdata", resp_rdata, '0);
        idle(1);
        line = {$urandom, $urandom, $urandom, $urandom};
        do_read(LA'($urandom), 1, line, -1, 1'b0);
        idle(1);

        // Long wait well inside any timeout limit
        line = {$urandom, $urandom, $urandom, $urandom};
        do_read(LA'($urandom), 30, line, -1, 1'b0);
        idle(1);

`ifdef C2_TIMEOUT_EN
        do_read(LA'($urandom), -1, '0, -1, 1'b0);
        idle(1);
`endif

        for (int i = 0; i < 40; i++) begin
            hold = (i < 39) && ($urandom_range(0, 3) == 0);
            line = {$urandom, $urandom, $urandom, $urandom};
            addr = LA'($urandom);
            dly  = int'($urandom_range(1, 6));
            if ($urandom_range(0, 1) == 1) do_write(addr, line, dly, hold, 1'b0);
            else                           do_read(addr, dly, line, -1, hold);
            if (!hold) idle(int'($urandom_range(0, 3)));
        end

        idle(3);
        chk_en = 1'b0;
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/c2_initiator.md
# c2_initiator

Cache-side master for the C2 memory bus: accepts one line-granular read or write request from the cache controller and performs it against the memory responder over the narrow C2 bus. A 128-bit line moves as BUS_SIZE-bit beats. The block sits between the cache FSM and the memory model. It owns the command/address lines and the bus data lines during write beats.

## Interface
- MEM_ADDR_SIZE, 19, byte address width
- CACHE_OFFSET_SIZE, 4, line offset bits; line address width LA = MEM_ADDR_SIZE-CACHE_OFFSET_SIZE (15)
- BUS_SIZE, 16, C2 data bus width
- CACHE_LINE_SIZE, 16, line size in bytes; NBEATS = CACHE_LINE_SIZE*8/BUS_SIZE (8)
- TIMEOUT_CYCLES, 100, wait limit, used only with C2_TIMEOUT_EN
- clk  in  1  clock; one clock, all logic on posedge
- reset  in  1  synchronous, active-high
- req_valid  in  1  request present
- req_ready  out  1  block idle, request accepted when req_valid&&req_ready
- req_write  in  1  1=write line, 0=read line
- req_addr  in  LA  line address
- req_wdata  in  CACHE_LINE_SIZE*8  write line, byte 0 in bits [7:0]
- resp_valid  out  1  one-cycle completion pulse
- resp_err  out  1  timeout flag, valid with resp_valid
- resp_rdata  out  CACHE_LINE_SIZE*8  read line, held until next read completes
- c2_addr  out  LA  bus line address
- c2_cmd_out  out  2  0 NOP, 2 READ, 3 WRITE
- c2_cmd_in  in  2  responder command; 1 RESPONSE
- c2_data_out  out  BUS_SIZE  write beat
- c2_data_oe  out  1  block drives bus data
- c2_data_in  in  BUS_SIZE  read beat

## Operation
- States: IDLE, RD_CMD, RD_WAIT, RD_DATA, WR_DATA, WR_WAIT, DONE. req_ready = (state==IDLE).
- IDLE: on handshake latch addr, wdata, write; go WR_DATA if write, else RD_CMD.
- RD_CMD (1 cycle): c2_cmd_out=READ, c2_addr=latched addr; -> RD_WAIT.
- RD_WAIT: c2_cmd_out=NOP; on c2_cmd_in==RESPONSE capture c2_data_in as beat 0 (bits [BUS_SIZE-1:0]), beat=1, -> RD_DATA. READ/WRITE/NOP on c2_cmd_in ignored.
- RD_DATA: capture c2_data_in into rdata[beat*BUS_SIZE +: BUS_SIZE] every cycle, c2_cmd_in ignored; after beat NBEATS-1 -> DONE.
- WR_DATA: NBEATS consecutive cycles, c2_cmd_out=WRITE, c2_addr valid, c2_data_oe=1, c2_data_out=wdata beat (beat 0 lowest); -> WR_WAIT after beat NBEATS-1.
- WR_WAIT: c2_cmd_out=NOP, c2_data_oe=0; on RESPONSE -> DONE. RESPONSE seen during WR_DATA ignored.
- DONE (1 cycle): resp_valid=1, resp_rdata updated only for reads; -> IDLE.
- Beat counter log2(NBEATS) bits, wraps to 0 on last beat; never carries into state.

## Timing
- All bus outputs registered. Reset values: c2_cmd_out=NOP, c2_addr=0, c2_data_out=0, c2_data_oe=0, resp_valid=0, resp_err=0, resp_rdata=0; state IDLE, so req_ready=1 the cycle after reset deasserts.
- Handshake at cycle T: READ on bus at T+1; RESPONSE earliest at T+2; resp_valid earliest at T+2+NBEATS (read), T+NBEATS+2 (write, RESPONSE at T+NBEATS+1).
- Back-to-back: next request accepted the cycle after resp_valid.
- Reset mid-transaction: abandon, bus returns to NOP/oe=0 next cycle, no resp_valid.

## Configuration
- C2_TIMEOUT_EN defined: counter runs in RD_WAIT/WR_WAIT; after TIMEOUT_CYCLES cycles without RESPONSE -> DONE with resp_err=1, resp_rdata unchanged. Counter clears on entering each wait state.
- Undefined: waits indefinitely; resp_err constant 0.

## Test plan
- Reset then idle -> req_ready=1, c2_cmd_out=0, c2_data_oe=0, resp_valid=0.
- Read addr 0x1234, responder RESPONSE 3 cycles after READ with beats 0x0001..0x0008 -> resp_rdata=0x0008_0007_..._0001, resp_err=0, one resp_valid pulse.
- Write addr 0x7FFF, wdata 0x0F0E..0100 by beat -> 8 cycles WRITE with c2_data_out 0x0100,0x0302,...,0x0F0E, oe=1; RESPONSE -> resp_valid.
- Back-to-back write then read, req_valid held -> second accepted cycle after first resp_valid.
- Reset asserted in RD_DATA beat 4 -> NOP next cycle, no resp_valid, fresh read completes correctly.
- C2_TIMEOUT_EN, no RESPONSE -> resp_valid with resp_err=1 exactly TIMEOUT_CYCLES after entering RD_WAIT.
